// File: rtl/fetch_ctrl.sv
// Instruction fetch sequencer: owns the fetch PC, buffers ROM reads in a 2-entry queue,
// and hands them to decode over valid/ready. Optional perf counters under `FETCH_PERF_EN.
module fetch_ctrl #(
  parameter logic [6:0]  RESET_PC = 7'd0,
  parameter int unsigned DEPTH    = 2
) (
  input  logic        clk,
  input  logic        rst,
  output logic [6:0]  rom_addr_o,
  input  logic [15:0] rom_inst_i,
  output logic [15:0] inst_o,
  output logic [6:0]  pc_o,
  output logic        inst_valid_o,
  input  logic        inst_ready_i,
  input  logic        redirect_i,
  input  logic [6:0]  redirect_pc_i,
  output logic [15:0] fetch_cnt_o,
  output logic [15:0] stall_cnt_o
);

  localparam int unsigned PcW   = 7;
  localparam int unsigned InstW = 16;
  localparam int unsigned CntW  = 2;

  logic [PcW-1:0]   fpc_q, fpc_d;
  logic [CntW-1:0]  count_q, count_d;
  logic [PcW-1:0]   head_pc_q, head_pc_d, tail_pc_q, tail_pc_d;
  logic [InstW-1:0] head_inst_q, head_inst_d, tail_inst_q, tail_inst_d;
  logic             valid_q, valid_d;
  logic             pop_c, push_c, full_c;

  assign full_c = (count_q == CntW'(DEPTH));
  assign pop_c  = valid_q && inst_ready_i;
  assign push_c = !redirect_i && (!full_c || pop_c);

  // Head is entry 0; on pop the tail shifts forward, new data lands behind whatever remains.
  always_comb begin
    fpc_d       = fpc_q;
    count_d     = count_q;
    head_pc_d   = head_pc_q;
    head_inst_d = head_inst_q;
    tail_pc_d   = tail_pc_q;
    tail_inst_d = tail_inst_q;
    if (redirect_i) begin
      fpc_d   = redirect_pc_i;
      count_d = '0;
    end else begin
      if (pop_c && count_q == CntW'(2)) begin
        head_pc_d   = tail_pc_q;
        head_inst_d = tail_inst_q;
      end
      if (push_c) begin
        fpc_d = fpc_q + PcW'(1);
        if (count_q == '0 || (pop_c && count_q == CntW'(1))) begin
          head_pc_d   = fpc_q;
          head_inst_d = rom_inst_i;
        end else begin
          tail_pc_d   = fpc_q;
          tail_inst_d = rom_inst_i;
        end
      end
      count_d = count_q + CntW'(push_c) - CntW'(pop_c);
    end
    valid_d = (count_d != '0);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fpc_q       <= RESET_PC;
      count_q     <= '0;
      valid_q     <= 1'b0;
      head_pc_q   <= '0;
      head_inst_q <= '0;
      tail_pc_q   <= '0;
      tail_inst_q <= '0;
    end else begin
      fpc_q       <= fpc_d;
      count_q     <= count_d;
      valid_q     <= valid_d;
      head_pc_q   <= head_pc_d;
      head_inst_q <= head_inst_d;
      tail_pc_q   <= tail_pc_d;
      tail_inst_q <= tail_inst_d;
    end
  end

  assign rom_addr_o   = fpc_q;
  assign inst_o       = head_inst_q;
  assign pc_o         = head_pc_q;
  assign inst_valid_o = valid_q;

`ifdef FETCH_PERF_EN
  localparam int unsigned PerfW = 16;
  logic [PerfW-1:0] fetch_cnt_q, fetch_cnt_d, stall_cnt_q, stall_cnt_d;

  // Saturating event counters.
  always_comb begin
    fetch_cnt_d = fetch_cnt_q;
    stall_cnt_d = stall_cnt_q;
    if (push_c && fetch_cnt_q != '1) fetch_cnt_d = fetch_cnt_q + PerfW'(1);
    if (valid_q && !inst_ready_i && stall_cnt_q != '1) stall_cnt_d = stall_cnt_q + PerfW'(1);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fetch_cnt_q <= '0;
      stall_cnt_q <= '0;
    end else begin
      fetch_cnt_q <= fetch_cnt_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign fetch_cnt_o = fetch_cnt_q;
  assign stall_cnt_o = stall_cnt_q;
`else
  assign fetch_cnt_o = 16'h0000;
  assign stall_cnt_o = 16'h0000;
`endif

endmodule

// File: tb/tb_fetch_ctrl.sv
// Directed bench for fetch_ctrl: reset, back-pressure, redirect, wrap, async reset.
module tb_fetch_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic [6:0]  rom_addr;
  logic [15:0] rom_inst;
  logic [15:0] inst;
  logic [6:0]  pc;
  logic        inst_valid;
  logic        inst_ready;
  logic        redirect;
  logic [6:0]  redirect_pc;
  logic [15:0] fetch_cnt;
  logic [15:0] stall_cnt;

  int checks = 0;
  int errors = 0;

  fetch_ctrl dut (
    .clk          (clk),
    .rst          (rst),
    .rom_addr_o   (rom_addr),
    .rom_inst_i   (rom_inst),
    .inst_o       (inst),
    .pc_o         (pc),
    .inst_valid_o (inst_valid),
    .inst_ready_i (inst_ready),
    .redirect_i   (redirect),
    .redirect_pc_i(redirect_pc),
    .fetch_cnt_o  (fetch_cnt),
    .stall_cnt_o  (stall_cnt)
  );

  always #5 clk = ~clk;

  assign rom_inst = 16'hA000 | {9'b0, rom_addr};

`ifdef FETCH_PERF_EN
  localparam logic [15:0] ExpStall = 16'd5;
  localparam logic [15:0] ExpFetch = 16'd2;
`else
  localparam logic [15:0] ExpStall = 16'd0;
  localparam logic [15:0] ExpFetch = 16'd0;
`endif

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_head(input string tag, input logic [6:0] exp_pc);
    chk({tag, "_valid"}, 32'(inst_valid), 32'd1);
    chk({tag, "_pc"}, 32'(pc), 32'(exp_pc));
    chk({tag, "_inst"}, 32'(inst), 32'(16'hA000 | {9'b0, exp_pc}));
  endtask

  initial begin
    rst = 1'b1;
    inst_ready = 1'b0;
    redirect = 1'b0;
    redirect_pc = 7'd0;
    #3;
    chk("rst_valid", 32'(inst_valid), 32'd0);
    chk("rst_pc", 32'(pc), 32'd0);
    chk("rst_inst", 32'(inst), 32'd0);
    chk("rst_addr", 32'(rom_addr), 32'd0);
    chk("rst_fcnt", 32'(fetch_cnt), 32'd0);
    chk("rst_scnt", 32'(stall_cnt), 32'd0);
    #9 rst = 1'b0;

    // Back-pressure: ready low for 5 cycles after first valid.
    step();
    chk_head("first", 7'd0);
    chk("first_addr", 32'(rom_addr), 32'd1);
    step();
    chk("bp2_addr", 32'(rom_addr), 32'd2);
    for (int i = 3; i <= 6; i++) begin
      step();
      chk_head("bp_hold", 7'd0);
      chk("bp_addr", 32'(rom_addr), 32'd2);
    end
    chk("bp_stall", 32'(stall_cnt), 32'(ExpStall));
    chk("bp_fetch", 32'(fetch_cnt), 32'(ExpFetch));

    // Release: 1,2,3 follow 0 without gap; queue stays full.
    inst_ready = 1'b1;
    step();
    chk_head("rel1", 7'd1);
    chk("rel1_addr", 32'(rom_addr), 32'd3);
    step();
    chk_head("rel2", 7'd2);
    step();
    chk_head("rel3", 7'd3);
    chk("rel3_addr", 32'(rom_addr), 32'd5);
    chk("rel_stall", 32'(stall_cnt), 32'(ExpStall));

    // Redirect to 5 while pc 3 is accepted; entry 4 is dropped.
    redirect = 1'b1;
    redirect_pc = 7'd5;
    step();
    redirect = 1'b0;
    chk("redir_bubble", 32'(inst_valid), 32'd0);
    chk("redir_addr", 32'(rom_addr), 32'd5);
    step();
    chk_head("redir_tgt", 7'd5);
    chk("redir_addr2", 32'(rom_addr), 32'd6);

    // Wrap across 127.
    redirect = 1'b1;
    redirect_pc = 7'd126;
    step();
    redirect = 1'b0;
    chk("wrap_bubble", 32'(inst_valid), 32'd0);
    chk("wrap_addr", 32'(rom_addr), 32'd126);
    step();
    chk_head("wrap126", 7'd126);
    step();
    chk_head("wrap127", 7'd127);
    chk("wrap_addr0", 32'(rom_addr), 32'd0);
    step();
    chk_head("wrap0", 7'd0);
    step();
    chk_head("wrap1", 7'd1);

    // Fill to 2 entries, then reset between edges.
    inst_ready = 1'b0;
    step();
    chk_head("full_hold", 7'd1);
    chk("full_addr", 32'(rom_addr), 32'd3);
    #2 rst = 1'b1;
    #1;
    chk("arst_valid", 32'(inst_valid), 32'd0);
    chk("arst_addr", 32'(rom_addr), 32'd0);
    chk("arst_pc", 32'(pc), 32'd0);
    chk("arst_inst", 32'(inst), 32'd0);
    chk("arst_fcnt", 32'(fetch_cnt), 32'd0);
    chk("arst_scnt", 32'(stall_cnt), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    inst_ready = 1'b1;
    step();
    chk_head("post_rst", 7'd0);
    step();
    chk_head("post_rst1", 7'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/fetch_ctrl.md
# fetch_ctrl

Instruction fetch sequencer between the CPU's 16-bit instruction ROM and decode.
- Owns the fetch program counter and drives the ROM's 7-bit address.
- Captures each combinational ROM read into a 2-entry prefetch queue.
- Presents instructions to decode over a valid/ready handshake.
- Handles branch redirects (e.g. a taken BNE) by flushing the queue and reloading the PC.

## Interface
- `RESET_PC`, default 7'd0, first fetch address after reset.
- `DEPTH`, default 2, prefetch queue depth; only 2 is supported.
- `clk` input, 1 bit: sole clock, rising edge.
- `rst` input, 1 bit: reset, asynchronous and active-high.
- `rom_addr_o` output, 7 bits: ROM address; combinational copy of the fetch PC register.
- `rom_inst_i` input, 16 bits: ROM data for `rom_addr_o`, valid in the same cycle.
- `inst_o` output, 16 bits: instruction at the queue head.
- `pc_o` output, 7 bits: address of `inst_o`.
- `inst_valid_o` output, 1 bit: queue non-empty; `inst_o` and `pc_o` are meaningful.
- `inst_ready_i` input, 1 bit: decode accepts the head this cycle.
- `redirect_i` input, 1 bit: branch taken; flush the queue and refetch.
- `redirect_pc_i` input, 7 bits: branch target.
- `fetch_cnt_o` output, 16 bits: pushes since reset (see Configuration).
- `stall_cnt_o` output, 16 bits: back-pressure cycles since reset (see Configuration).

## Operation
- **State:** `fpc` (7 bits), queue of {pc, inst} entries, `count` (0..2).
- **Pop:** occurs when `inst_valid_o && inst_ready_i`.
- **Push:** occurs when `!redirect_i && (count < 2 || pop)`.
  - Writes {`fpc`, `rom_inst_i`} at the tail.
  - Sets `fpc <= fpc + 1`, modulo 128, so 127 wraps to 0.
- **Full queue without pop:** no push; `fpc` holds and `rom_addr_o` is stable.
- **Simultaneous push and pop:** allowed in any state, including full, so sustained throughput is 1 instruction/cycle.
- **Redirect (highest priority):**
  - At the edge, `count <= 0` and `fpc <= redirect_pc_i`; no push occurs.
  - A pop in the same cycle still counts as accepted; the head is the branch itself.
  - Every other queued entry is discarded.
- **Redirect to the current `fpc`:** still flushes.
- **Redirect while the queue is empty:** behaves identically.
- **Outputs:** `inst_o` and `pc_o` always show the head entry. When `count == 0` they hold their last value; decode must qualify them with `inst_valid_o`.
- **No internal FSM beyond the occupancy count:**
  - EMPTY (`count` = 0) -> ONE on push.
  - ONE -> TWO on push without pop.
  - TWO -> ONE on pop without push.
  - Any state -> EMPTY on redirect.
- **Reset:** an asynchronous `rst` at any time, including mid-redirect, immediately sets:
  - `fpc` = `RESET_PC`, `count` = 0.
  - `inst_valid_o` = 0, `inst_o` = 16'h0000, `pc_o` = 7'h00.
  - Both counters = 0, and `rom_addr_o` = `RESET_PC`.

## Timing
- **Reset release:** first edge after `rst` falls pushes `RESET_PC`; `inst_valid_o` rises after that edge.
- **Fetch latency:** 1 cycle from `rom_addr_o` presentation to `inst_valid_o`.
- **Redirect in cycle N:**
  - Cycle N+1: `inst_valid_o` = 0 and `rom_addr_o` = target.
  - Cycle N+2: `inst_valid_o` = 1 with `pc_o` = target.
  - Penalty is exactly 1 bubble cycle.
- **Combinational paths:** `inst_ready_i` reaches the internal push enable only, never `inst_valid_o`. No combinational path from any input to `inst_valid_o`, `inst_o` or `pc_o`.
- **Addressing:** `rom_addr_o` changes only at clock edges or on asynchronous reset.

## Configuration
- **`FETCH_PERF_EN` defined:**
  - `fetch_cnt_o` increments on each push.
  - `stall_cnt_o` increments each cycle with `inst_valid_o && !inst_ready_i`.
  - Both are 16-bit and saturate at 16'hFFFF.
- **`FETCH_PERF_EN` undefined:** ports remain present; both outputs are tied to 16'h0000 and the counter registers are not built.

## Test plan
ROM model returns 16'hA000 | addr.
- **Reset + stream:** release `rst`, hold `inst_ready_i` = 1 -> `pc_o` sequence 0,1,2,3… one per cycle; `inst_o` = 16'hA000, 16'hA001…; `inst_valid_o` high from the 1st edge onward.
- **Back-pressure:** `inst_ready_i` = 0 for 5 cycles after the first valid.
  - `count` reaches 2 and `rom_addr_o` holds at 2.
  - `pc_o` stays 0, and `stall_cnt_o` = 5 when `FETCH_PERF_EN` is defined.
  - On release, 0,1,2 are delivered with no gap or duplicate.
- **Redirect:**
  - `redirect_i` = 1 with `redirect_pc_i` = 7'd5 in the cycle `pc_o` = 3 is accepted.
  - Expect one bubble, then `pc_o` = 5, `inst_o` = 16'hA005.
  - Entry 4 is never delivered.
- **Wrap:** `redirect_pc_i` = 7'd126 with ready high -> `pc_o` 126, 127, 0, 1.
- **Async reset mid-stream:** assert `rst` between edges while `count` = 2 -> `inst_valid_o` = 0 and `rom_addr_o` = 0 immediately, before the next edge; counters read 0.
- **Macro off:** rerun the back-pressure scenario without `FETCH_PERF_EN` -> `fetch_cnt_o` = `stall_cnt_o` = 0 throughout; functional outputs are identical to the macro-on run.
